arb_req_tracker: RTL and testbench
==================================

# arb_req_tracker

Upstream request-conditioning stage for the 4-way priority arbiter. Accepts single-cycle request pulses from each client and keeps a saturating per-client pending count. Drives the level-sensitive `req` vector and the one-hot `priv` priority vector into the arbiter, and retires one pending request per valid grant. Optional aging rotates `priv` so that no client starves behind a fixed priority.

## Interface
- `N`, 4: number of clients; all vectors are N bits wide.
- `CNT_W`, 2: pending counter width; a client holds at most 2^CNT_W−1 pending requests (3 at default).
- `PRIV_RST`, 4'b0001: reset value of `priv`; must be one-hot.

- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `req_in`  input  N  per-client request pulse; one request per client per cycle.
- `req_full`  output  N  client pending count is at maximum.
- `req`  output  N  pending-request vector to the arbiter.
- `priv`  output  N  one-hot priority vector to the arbiter.
- `grant`  input  N  grant vector from the arbiter.
- `vld`  input  1  qualifies `grant`.
- `ovf`  output  N  sticky per client: a request was dropped because the client was full.
- `gnt_err`  output  1  sticky: an illegal grant was received.

## Operation
- Each client i has a counter `cnt[i]` (CNT_W bits). Reset value is 0.
- Increment condition: `req_in[i]` is high and the count is below maximum.
- Decrement condition: a legal grant is present (`vld` high, `grant` one-hot) with `grant[i]` high and `cnt[i]` > 0.
- Increment and decrement in the same cycle leave the count unchanged. This holds even when the count is at maximum: the request is accepted because a slot frees in the same cycle.
- `req_in[i]` while the count is at maximum and there is no same-cycle decrement: the request is dropped, the count is unchanged, and `ovf[i]` is set.
- Illegal grant: `vld` high with `grant` zero or not one-hot, or a legal grant to a client whose count is 0.
  - Sets `gnt_err`.
  - No counter changes.
  - `priv` does not rotate.
- `req[i]` = (`cnt[i]` != 0) AND NOT (`cnt[i]` == 1 AND a legal grant to i in this cycle). This is combinational masking, so the arbiter never sees a stale request for a slot that is being retired.
- `req_full[i]` = (`cnt[i]` == max), from the registered count. It reflects no same-cycle grant look-ahead.
- Aging (when compiled in). Let `priv` = bit p. On a legal grant, `priv` rotates left by one (the MSB wraps to the LSB) in either of these cases:
  - the grant went to p;
  - `cnt[p]` == 0.
  
  Otherwise `priv` holds. `priv` is always exactly one-hot.
- `ovf` and `gnt_err` clear only on reset.

## Timing
- Reset values: all `cnt` = 0, `req` = 0, `req_full` = 0, `priv` = PRIV_RST, `ovf` = 0, `gnt_err` = 0.
- Reset assertion mid-operation clears all state immediately, without waiting for a clock edge.
- Latency from request to `req`: a `req_in` pulse in cycle t gives `req` high from cycle t+1.
- Latency from grant to `req` drop: a legal grant in cycle t to a client with count 1 drops `req` combinationally in cycle t. The count reaches 0 at the end of cycle t.
- `priv` changes take effect one cycle after the qualifying grant.
- There is no backpressure handshake to clients beyond `req_full`. Clients must not pulse `req_in` while `req_full` is high, unless they accept a drop.

## Configuration
- `ARB_REQ_AGING_EN` defined: `priv` rotates as described in Operation.
- `ARB_REQ_AGING_EN` not defined: `priv` is held constant at PRIV_RST. The rotation logic and its register are not built. All other behaviour is identical.

## Test plan
- Reset, then idle → `req` = 0, `priv` = 0001, `ovf` = 0, `gnt_err` = 0. Assert `reset` mid-burst with counts non-zero → all outputs return to reset values with no clock edge.
- `req_in` = 0010 for 4 consecutive cycles, no grants → count 3; `req_full[1]` high after the 3rd pulse; 4th pulse dropped; `ovf` = 0010.
- Client 1 at count 3: in one cycle, `req_in[1]` = 1 with a legal grant 0010 → count stays 3, `ovf` unchanged. Next, three single grants 0010 → `req[1]` drops in the same cycle as the third grant.
- `vld` = 1 with `grant` = 0110, then `vld` = 1 with `grant` = 0100 while `cnt[2]` = 0 → `gnt_err` = 1, no count change, `priv` unchanged.
- With aging on and `priv` = 0100, clients 1 and 2 pending: legal grant 0100 → `priv` = 1000 next cycle. Then `cnt[3]` = 0 and a legal grant 0010 → `priv` = 0001 (wrap-around).
- With aging off, repeat the previous scenario → `priv` stays 0001 throughout.

Source files
------------

// File: rtl/arb_req_tracker.sv
// Request-conditioning stage ahead of the N-way priority arbiter: per-client saturating pending
// counts, masked req vector, one-hot priv vector. Aging rotation is built when ARB_REQ_AGING_EN.
module arb_req_tracker #(
  parameter int unsigned   N        = 4,
  parameter int unsigned   CNT_W    = 2,
  parameter logic [N-1:0]  PRIV_RST = 4'b0001
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req_in,
  output logic [N-1:0] req_full,
  output logic [N-1:0] req,
  output logic [N-1:0] priv,
  input  logic [N-1:0] grant,
  input  logic         vld,
  output logic [N-1:0] ovf,
  output logic         gnt_err
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);
  localparam logic [N-1:0]     VecOne = N'(1);

  logic [CNT_W-1:0] cnt_q [N];
  logic [CNT_W-1:0] cnt_d [N];
  logic [N-1:0]     nz;
  logic [N-1:0]     full;
  logic [N-1:0]     dec;
  logic [N-1:0]     inc;
  logic [N-1:0]     drop;
  logic             grant_onehot;
  logic             legal;
  logic             illegal;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      nz[i]   = cnt_q[i] != '0;
      full[i] = cnt_q[i] == CntMax;
    end
    grant_onehot = (grant != '0) && ((grant & (grant - VecOne)) == '0);
    // A grant to an empty client is illegal and must not retire anything.
    legal   = vld && grant_onehot && ((grant & nz) != '0);
    illegal = vld && !legal;
    dec     = legal ? grant : '0;
    for (int unsigned i = 0; i < N; i++) begin
      // At max a request is still accepted if a slot frees in the same cycle.
      inc[i]  = req_in[i] && (!full[i] || dec[i]);
      drop[i] = req_in[i] && full[i] && !dec[i];
      cnt_d[i] = cnt_q[i];
      if (inc[i] && !dec[i]) begin
        cnt_d[i] = cnt_q[i] + CntOne;
      end else if (dec[i] && !inc[i]) begin
        cnt_d[i] = cnt_q[i] - CntOne;
      end
      req[i] = nz[i] && !((cnt_q[i] == CntOne) && dec[i]);
    end
    req_full = full;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= '0;
      end
      ovf     <= '0;
      gnt_err <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      ovf <= ovf | drop;
      if (illegal) begin
        gnt_err <= 1'b1;
      end
    end
  end

`ifdef ARB_REQ_AGING_EN
  logic [N-1:0] priv_q;
  logic         rotate;

  // Advance when the priority holder is served or has nothing pending.
  assign rotate = legal && (((grant & priv_q) != '0) || ((priv_q & nz) == '0));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      priv_q <= PRIV_RST;
    end else if (rotate) begin
      priv_q <= {priv_q[N-2:0], priv_q[N-1]};
    end
  end

  assign priv = priv_q;
`else
  assign priv = PRIV_RST;
`endif

endmodule

// File: tb/tb_arb_req_tracker.sv
// Directed table-driven bench for arb_req_tracker; aging checks follow ARB_REQ_AGING_EN.
module tb_arb_req_tracker;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_in;
  logic [3:0] req_full;
  logic [3:0] req;
  logic [3:0] priv;
  logic [3:0] grant;
  logic       vld;
  logic [3:0] ovf;
  logic       gnt_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  arb_req_tracker dut (
    .clk      (clk),
    .reset    (reset),
    .req_in   (req_in),
    .req_full (req_full),
    .req      (req),
    .priv     (priv),
    .grant    (grant),
    .vld      (vld),
    .ovf      (ovf),
    .gnt_err  (gnt_err)
  );

  typedef struct {
    logic [3:0] req_in;
    logic [3:0] grant;
    logic       vld;
    logic [3:0] exp_req;
    logic [3:0] exp_full;
    logic [3:0] exp_ovf;
    logic       exp_err;
  } vec_t;

  typedef struct {
    logic [3:0] req_in;
    logic [3:0] grant;
    logic       vld;
    logic [3:0] exp_priv_aging;
  } age_t;

  vec_t vt[21];
  age_t at[8];

  task automatic chk_vec(input string name, input logic [3:0] r, input logic [3:0] f,
                         input logic [3:0] o, input logic e, input logic [3:0] p);
    n_vec++;
    if (req !== r || req_full !== f || ovf !== o || gnt_err !== e || priv !== p) begin
      n_err++;
      $display("FAIL %s: got req=%b full=%b ovf=%b err=%b priv=%b, want req=%b full=%b ovf=%b err=%b priv=%b",
               name, req, req_full, ovf, gnt_err, priv, r, f, o, e, p);
    end
  endtask

  task automatic chk_priv(input string name, input logic [3:0] p);
    n_vec++;
    if (priv !== p) begin
      n_err++;
      $display("FAIL %s: got priv=%b, want %b", name, priv, p);
    end
  endtask

  initial begin
    // req_in, grant, vld, exp req, exp full, exp ovf, exp err (pre-edge view)
    vt[0]  = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vt[1]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0};
    vt[2]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0};
    vt[3]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0000, 4'b0000, 1'b0};
    vt[4]  = '{4'b0010, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b0000, 1'b0};
    vt[5]  = '{4'b0000, 4'b0000, 1'b0, 4'b0010, 4'b0010, 4'b0010, 1'b0};
    vt[6]  = '{4'b0010, 4'b0010, 1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b0};
    vt[7]  = '{4'b0000, 4'b0010, 1'b1, 4'b0010, 4'b0010, 4'b0010, 1'b0};
    vt[8]  = '{4'b0000, 4'b0010, 1'b1, 4'b0010, 4'b0000, 4'b0010, 1'b0};
    vt[9]  = '{4'b0000, 4'b0010, 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b0};
    vt[10] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0};
    vt[11] = '{4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b0};
    vt[12] = '{4'b0000, 4'b0110, 1'b1, 4'b0001, 4'b0000, 4'b0010, 1'b0};
    vt[13] = '{4'b0000, 4'b0100, 1'b1, 4'b0001, 4'b0000, 4'b0010, 1'b1};
    vt[14] = '{4'b0000, 4'b0000, 1'b1, 4'b0001, 4'b0000, 4'b0010, 1'b1};
    vt[15] = '{4'b0000, 4'b0000, 1'b0, 4'b0001, 4'b0000, 4'b0010, 1'b1};
    vt[16] = '{4'b0000, 4'b0001, 1'b1, 4'b0000, 4'b0000, 4'b0010, 1'b1};
    vt[17] = '{4'b0000, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b1};
    vt[18] = '{4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b0000, 4'b0010, 1'b1};
    vt[19] = '{4'b0101, 4'b1000, 1'b1, 4'b0111, 4'b0000, 4'b0010, 1'b1};
    vt[20] = '{4'b0000, 4'b0000, 1'b0, 4'b0111, 4'b0000, 4'b0010, 1'b1};

    // req_in, grant, vld, priv after the edge when aging is built
    at[0] = '{4'b0111, 4'b0000, 1'b0, 4'b0001};
    at[1] = '{4'b0110, 4'b0000, 1'b0, 4'b0001};
    at[2] = '{4'b0000, 4'b0001, 1'b1, 4'b0010};
    at[3] = '{4'b0000, 4'b0100, 1'b1, 4'b0010};
    at[4] = '{4'b0000, 4'b0010, 1'b1, 4'b0100};
    at[5] = '{4'b0000, 4'b0100, 1'b1, 4'b1000};
    at[6] = '{4'b0000, 4'b1000, 1'b1, 4'b1000};
    at[7] = '{4'b0000, 4'b0010, 1'b1, 4'b0001};

    reset  = 1'b1;
    req_in = '0;
    grant  = '0;
    vld    = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1 chk_priv("reset_priv", 4'b0001);

    // Table vectors; priv is only compared where it cannot have rotated.
    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      req_in = vt[i].req_in;
      grant  = vt[i].grant;
      vld    = vt[i].vld;
      #1;
      n_vec++;
      if (req !== vt[i].exp_req || req_full !== vt[i].exp_full || ovf !== vt[i].exp_ovf ||
          gnt_err !== vt[i].exp_err) begin
        n_err++;
        $display("FAIL vec%0d: got req=%b full=%b ovf=%b err=%b, want req=%b full=%b ovf=%b err=%b",
                 i, req, req_full, ovf, gnt_err, vt[i].exp_req, vt[i].exp_full,
                 vt[i].exp_ovf, vt[i].exp_err);
      end
    end

    // Asynchronous reset with counts pending: outputs clear before any edge.
    @(negedge clk);
    req_in = '0;
    grant  = '0;
    vld    = 1'b0;
    #1 chk_vec("pre_reset", 4'b0111, 4'b0000, 4'b0010, 1'b1, priv);
    reset = 1'b1;
    #1 chk_vec("async_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001);
    @(negedge clk);
    reset = 1'b0;
    #1 chk_vec("post_reset", 4'b0000, 4'b0000, 4'b0000, 1'b0, 4'b0001);

    // Aging sequence: rotate on holder grant or empty holder, hold otherwise.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req_in = at[i].req_in;
      grant  = at[i].grant;
      vld    = at[i].vld;
      @(posedge clk);
      #1;
`ifdef ARB_REQ_AGING_EN
      chk_priv($sformatf("age%0d", i), at[i].exp_priv_aging);
`else
      chk_priv($sformatf("noage%0d", i), 4'b0001);
`endif
    end
    @(negedge clk);
    req_in = '0;
    grant  = '0;
    vld    = 1'b0;
    #1 chk_vec("age_end", 4'b0000, 4'b0000, 4'b0000, 1'b1, priv);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
